instruction_decode_hz: RTL and testbench
========================================

// Module: instruction_decode_hz
// PURPOSE
//  Parametrised ID stage for the 5-stage MIPS pipeline, between IF/ID and EX.
//  Integrates the register file with WB->ID write bypass and decodes R-type
//  (add/sub/and/or/slt), lw, sw, beq, bne and j. Detects load-use hazards and
//  stalls IF; accepts a flush from branch/jump resolution. Registers the
//  ID/EX pipeline fields with a valid bit and a saturating stall counter.
// PARAMETERS
//  DATA_W      32  datapath/PC width; >=32; instruction is always 32 bits
//  NUM_REGS    32  register count; <=32, indexed by IR[25:21]/[20:16]/[15:11]
//  WB_BYPASS   1   1: same-cycle WB write visible to ID read; 0: no bypass
//  CNT_W       16  width of the stall performance counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-low reset
//  PC           in   DATA_W   IF/ID PC (already PC+4)
//  IR           in   32       IF/ID instruction
//  if_valid     in   1        IR/PC hold a real instruction
//  flush        in   1        kill instruction in ID (taken branch/jump)
//  DX_MemRead   in   1        instruction now in EX is a load
//  DX_RD_in     in   5        its destination register
//  MW_RegWrite  in   1        WB write enable
//  MW_MemtoReg  in   1        WB selects MDR (1) or MW_ALUout (0)
//  MW_RD        in   5        WB destination
//  MDR          in   DATA_W   WB load data
//  MW_ALUout    in   DATA_W   WB ALU result
//  stall        out  1        combinational: IF must hold PC and IR
//  MemtoReg, RegWrite, MemRead, MemWrite, branch, bne, jump  out 1 each, ID/EX
//  ALUctr       out  3        0 add,1 sub,2 and,3 or,4 slt
//  A, B, MD     out  DATA_W   rs value; ALU operand 2; rt value (store data)
//  imm          out  DATA_W   sign-extended IR[15:0]
//  RD           out  5        destination register
//  JT, DX_PC, NPC  out DATA_W jump target; PC; PC
//  dx_valid     out  1        ID/EX slot holds a real instruction
//  illegal      out  1        one-cycle pulse: undecodable instruction seen
//  stall_cnt    out  CNT_W    load-use stall cycles, saturating
// BEHAVIOUR
//  - Reset: every output and all registers 0 (incl. regfile), stall_cnt 0.
//  - Latency 1: ID/EX outputs update on the clk after IR is presented.
//  - Regfile: write on posedge when MW_RegWrite && MW_RD!=0 && MW_RD<NUM_REGS;
//    reg0 reads 0; index >= NUM_REGS reads 0, writes ignored.
//    WB_BYPASS=1: read addr == MW_RD (nonzero) with MW_RegWrite returns write data.
//  - Decode: R: B=rt val, RD=IR[15:11], RegWrite. lw: B=imm, RD=IR[20:16],
//    MemRead, MemtoReg, RegWrite, add. sw: B=imm, MemWrite, MD=rt val, add, RD=0.
//    beq/bne: B=rt val, sub, branch / bne, RD=0. j: jump=1, no write.
//    JT={PC[DATA_W-1:28], IR[25:0], 2'b00}.
//  - Hazard: stall=1 when dx_valid && DX_MemRead && DX_RD_in!=0 && if_valid
//    && (DX_RD_in==rs || (DX_RD_in==rt && op in {R, sw, beq, bne})).
//  - Bubble (dx_valid=0, all control bits 0, RD=0; data fields don't-care) is
//    loaded when: stall, flush, !if_valid, or illegal op/funct.
//  - flush has priority: flush && hazard -> bubble, stall=0.
//  - illegal: registered pulse when if_valid && !flush && unknown opcode/funct.
//  - stall_cnt increments each cycle stall=1; holds at 2^CNT_W-1.
//  - Reset mid-stall: stall deasserts with dx_valid=0 on next evaluation.
// STRUCTURE
//  - Package id_pkg: opcode/funct localparams (0,35,43,4,5,2; funct 32,34,36,37,42),
//    ALUctr codes, hazard-relevant opcode set.
//  - Sub-module id_regfile (2R1W, NUM_REGS, DATA_W, WB_BYPASS).
//  - Top: decode/hazard combinational logic + ID/EX register + stall counter.
// TESTING
//  1 WB r3<=0x1234 same cycle as ID reads r3 (WB_BYPASS=1) -> A=0x00001234.
//  2 lw r5 in EX (DX_MemRead=1), ID: add r6,r5,r1 -> stall=1, dx_valid=0, cnt=1.
//  3 ID sw r5,4(r2) with load r5 in EX and flush=1 -> stall=0, bubble, cnt unchanged.
//  4 bne r1,r2 (IR=0x14220003) -> bne=1, branch=0, ALUctr=1, imm=3, RegWrite=0.
//  5 j 0x0000040 with PC=0xA0000004 -> jump=1, JT=0xA0000100.
//  6 opcode 6'd63 -> illegal pulses 1 cycle, dx_valid=0; write to r0 -> reads 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage.
//  - MIPS opcode / funct encodings for the supported instruction subset
//  - ALU control codes driven into EX
//  - control bundles: the part registered into ID/EX and the decode-only part
//  - decode() maps opcode/funct to a control bundle; reads_rt() marks the
//    opcodes whose rt field is a source operand (relevant to load-use hazards)
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctr_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RT   = 2'd1,
    DST_RD   = 2'd2
  } dst_e;

  typedef struct packed {
    logic     mem_to_reg;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     bne;
    logic     jump;
    alu_ctr_e alu_ctr;
  } ex_ctrl_t;

  typedef struct packed {
    ex_ctrl_t ex;
    dst_e     dst;
    logic     use_imm_b;
    logic     legal;
  } id_ctrl_t;

  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic id_ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    id_ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.dst          = DST_RD;
        c.ex.reg_write = 1'b1;
        c.legal        = 1'b1;
        case (funct)
          FN_ADD:  c.ex.alu_ctr = ALU_ADD;
          FN_SUB:  c.ex.alu_ctr = ALU_SUB;
          FN_AND:  c.ex.alu_ctr = ALU_AND;
          FN_OR:   c.ex.alu_ctr = ALU_OR;
          FN_SLT:  c.ex.alu_ctr = ALU_SLT;
          default: c.legal      = 1'b0;
        endcase
      end
      OP_LW: begin
        c.dst           = DST_RT;
        c.use_imm_b     = 1'b1;
        c.ex.mem_read   = 1'b1;
        c.ex.mem_to_reg = 1'b1;
        c.ex.reg_write  = 1'b1;
        c.ex.alu_ctr    = ALU_ADD;
        c.legal         = 1'b1;
      end
      OP_SW: begin
        c.use_imm_b    = 1'b1;
        c.ex.mem_write = 1'b1;
        c.ex.alu_ctr   = ALU_ADD;
        c.legal        = 1'b1;
      end
      OP_BEQ: begin
        c.ex.branch  = 1'b1;
        c.ex.alu_ctr = ALU_SUB;
        c.legal      = 1'b1;
      end
      OP_BNE: begin
        c.ex.bne     = 1'b1;
        c.ex.alu_ctr = ALU_SUB;
        c.legal      = 1'b1;
      end
      OP_J: begin
        c.ex.jump = 1'b1;
        c.legal   = 1'b1;
      end
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file for the ID stage.
//  clk, rst          clock; asynchronous active-low reset clears every entry
//  rs_addr, rt_addr  read addresses; rs_data, rt_data combinational read data
//  wr_en, wr_addr,   write port, committed on the rising edge
//  wr_data
// Register 0 and indices at or above NUM_REGS always read 0 and ignore writes.
// With WB_BYPASS=1 a read of the register being written this cycle returns
// the write data instead of the stale entry.
module id_regfile #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam logic [5:0] NREG = 6'(NUM_REGS);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;

  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NREG);
  endfunction

  assign wr_ok = wr_en && in_range(wr_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = '0;
    if (in_range(rs_addr)) begin
      if (WB_BYPASS != 0 && wr_en && rs_addr == wr_addr) rs_data = wr_data;
      else                                               rs_data = mem[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (in_range(rt_addr)) begin
      if (WB_BYPASS != 0 && wr_en && rt_addr == wr_addr) rt_data = wr_data;
      else                                               rt_data = mem[rt_addr];
    end
  end

endmodule

// File: rtl/instruction_decode_hz.sv
// ID stage of the 5-stage MIPS pipeline: register read with WB bypass,
// instruction decode, load-use hazard detection and the ID/EX register.
//  clk, rst            clock; asynchronous active-low reset
//  PC, IR, if_valid    IF/ID contents (PC already PC+4)
//  flush               kill the instruction in ID (taken branch / jump)
//  DX_MemRead,DX_RD_in load currently in EX and its destination
//  MW_RegWrite, MW_MemtoReg, MW_RD, MDR, MW_ALUout   WB write-back port
//  stall               combinational: IF holds PC and IR
//  MemtoReg..jump, ALUctr, A, B, MD, imm, RD, JT, DX_PC, NPC, dx_valid
//                      ID/EX pipeline fields
//  illegal             one-cycle pulse for an undecodable instruction
//  stall_cnt           saturating count of load-use stall cycles
module instruction_decode_hz
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PC,
  input  logic [31:0]       IR,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              DX_MemRead,
  input  logic [4:0]        DX_RD_in,
  input  logic              MW_RegWrite,
  input  logic              MW_MemtoReg,
  input  logic [4:0]        MW_RD,
  input  logic [DATA_W-1:0] MDR,
  input  logic [DATA_W-1:0] MW_ALUout,
  output logic              stall,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              branch,
  output logic              bne,
  output logic              jump,
  output logic [2:0]        ALUctr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] MD,
  output logic [DATA_W-1:0] imm,
  output logic [4:0]        RD,
  output logic [DATA_W-1:0] JT,
  output logic [DATA_W-1:0] DX_PC,
  output logic [DATA_W-1:0] NPC,
  output logic              dx_valid,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [5:0]               op;
  logic [5:0]               funct;
  logic [4:0]               rs;
  logic [4:0]               rt;
  logic [DATA_W-1:0]        rs_val;
  logic [DATA_W-1:0]        rt_val;
  logic [DATA_W-1:0]        wb_data;
  logic signed [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0]        op2;
  logic [DATA_W-1:0]        jt_addr;
  logic [4:0]               dst_reg;
  id_ctrl_t                 ctrl;
  logic                     hazard;
  logic                     bubble;
  logic                     illegal_now;
  logic                     unused_shamt;

  // ID/EX pipeline registers
  logic                     vld_p1;
  ex_ctrl_t                 ex_p1;
  logic [4:0]               rd_p1;
  logic [DATA_W-1:0]        a_p1;
  logic [DATA_W-1:0]        b_p1;
  logic [DATA_W-1:0]        md_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]        jt_p1;
  logic [DATA_W-1:0]        pc_p1;
  logic                     illegal_p1;
  logic [CNT_W-1:0]         stall_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign op           = IR[31:26];
  assign rs           = IR[25:21];
  assign rt           = IR[20:16];
  assign funct        = IR[5:0];
  // shift amount has no consumer in this instruction subset
  assign unused_shamt = ^IR[10:6];

  assign wb_data = MW_MemtoReg ? MDR : MW_ALUout;

  id_regfile #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_val),
    .rt_data (rt_val),
    .wr_en   (MW_RegWrite),
    .wr_addr (MW_RD),
    .wr_data (wb_data)
  );

  // Stage p0: decode, operand select and hazard detection
  assign ctrl    = decode(op, funct);
  assign imm_ext = {{(DATA_W-16){IR[15]}}, IR[15:0]};
  assign op2     = ctrl.use_imm_b ? $unsigned(imm_ext) : rt_val;
  assign jt_addr = {PC[DATA_W-1:28], IR[25:0], 2'b00};

  always_comb begin
    dst_reg = 5'd0;
    case (ctrl.dst)
      DST_RT:  dst_reg = rt;
      DST_RD:  dst_reg = IR[15:11];
      default: dst_reg = 5'd0;
    endcase
  end

  // rs is compared for every opcode; rt only where it is a source operand
  assign hazard = vld_p1 && DX_MemRead && (DX_RD_in != 5'd0) && if_valid &&
                  ((DX_RD_in == rs) || ((DX_RD_in == rt) && reads_rt(op)));

  // a flushed instruction never needs to wait for its operands
  assign stall       = hazard && !flush;
  assign bubble      = flush || !if_valid || stall || !ctrl.legal;
  assign illegal_now = if_valid && !flush && !ctrl.legal;

  // Stage p1: ID/EX register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      ex_p1       <= '0;
      rd_p1       <= '0;
      a_p1        <= '0;
      b_p1        <= '0;
      md_p1       <= '0;
      imm_p1      <= '0;
      jt_p1       <= '0;
      pc_p1       <= '0;
      illegal_p1  <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      vld_p1     <= !bubble;
      ex_p1      <= bubble ? '0 : ctrl.ex;
      rd_p1      <= bubble ? 5'd0 : dst_reg;
      a_p1       <= rs_val;
      b_p1       <= op2;
      md_p1      <= rt_val;
      imm_p1     <= imm_ext;
      jt_p1      <= jt_addr;
      pc_p1      <= PC;
      illegal_p1 <= illegal_now;
      if (stall) stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign dx_valid  = vld_p1;
  assign MemtoReg  = ex_p1.mem_to_reg;
  assign RegWrite  = ex_p1.reg_write;
  assign MemRead   = ex_p1.mem_read;
  assign MemWrite  = ex_p1.mem_write;
  assign branch    = ex_p1.branch;
  assign bne       = ex_p1.bne;
  assign jump      = ex_p1.jump;
  assign ALUctr    = ex_p1.alu_ctr;
  assign RD        = rd_p1;
  assign A         = a_p1;
  assign B         = b_p1;
  assign MD        = md_p1;
  assign imm       = imm_p1;
  assign JT        = jt_p1;
  assign DX_PC     = pc_p1;
  assign NPC       = pc_p1;
  assign illegal   = illegal_p1;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_instruction_decode_hz.sv
module tb_instruction_decode_hz;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0, IR = '0;
  logic        if_valid = 1'b0, flush = 1'b0;
  logic        DX_MemRead = 1'b0;
  logic [4:0]  DX_RD_in = '0;
  logic        MW_RegWrite = 1'b0, MW_MemtoReg = 1'b0;
  logic [4:0]  MW_RD = '0;
  logic [31:0] MDR = '0, MW_ALUout = '0;
  logic        stall, MemtoReg, RegWrite, MemRead, MemWrite, branch, bne, jump;
  logic [2:0]  ALUctr;
  logic [31:0] A, B, MD, imm, JT, DX_PC, NPC;
  logic [4:0]  RD;
  logic        dx_valid, illegal;
  logic [1:0]  stall_cnt;

  instruction_decode_hz #(.DATA_W(32), .NUM_REGS(32), .WB_BYPASS(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .PC(PC), .IR(IR), .if_valid(if_valid), .flush(flush),
    .DX_MemRead(DX_MemRead), .DX_RD_in(DX_RD_in), .MW_RegWrite(MW_RegWrite),
    .MW_MemtoReg(MW_MemtoReg), .MW_RD(MW_RD), .MDR(MDR), .MW_ALUout(MW_ALUout),
    .stall(stall), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .branch(branch), .bne(bne), .jump(jump), .ALUctr(ALUctr),
    .A(A), .B(B), .MD(MD), .imm(imm), .RD(RD), .JT(JT), .DX_PC(DX_PC), .NPC(NPC),
    .dx_valid(dx_valid), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%08h required=%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mrf [32];
  logic        e_valid, e_mtr, e_rw, e_mr, e_mw, e_br, e_bne, e_j, e_ill;
  logic [2:0]  e_alu;
  logic [4:0]  e_rd;
  logic [31:0] e_A, e_B, e_MD, e_imm, e_JT, e_PC;
  logic [1:0]  e_cnt;

  function automatic logic [31:0] mread(input logic [4:0] a);
    logic [31:0] wd;
    wd = MW_MemtoReg ? MDR : MW_ALUout;
    if (a == 5'd0) return 32'd0;
    if (MW_RegWrite && a == MW_RD) return wd;
    return mrf[a];
  endfunction

  function automatic logic exp_stall();
    logic [5:0] op;
    logic       rt_src;
    op = IR[31:26];
    rt_src = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5);
    return e_valid && DX_MemRead && DX_RD_in != 5'd0 && if_valid && !flush &&
           (DX_RD_in == IR[25:21] || (DX_RD_in == IR[20:16] && rt_src));
  endfunction

  task automatic model_reset();
    e_valid = 0; e_mtr = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_br = 0; e_bne = 0; e_j = 0;
    e_ill = 0; e_alu = 0; e_rd = 0; e_A = 0; e_B = 0; e_MD = 0; e_imm = 0; e_JT = 0;
    e_PC = 0; e_cnt = 0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
  endtask

  task automatic model_step();
    logic [5:0] op, fn;
    logic       st, legal, bub;
    logic [2:0] alu;
    op = IR[31:26]; fn = IR[5:0];
    st = exp_stall();
    legal = 1'b1; alu = 3'd0;
    case (op)
      6'd0: case (fn)
              6'd32: alu = 3'd0;
              6'd34: alu = 3'd1;
              6'd36: alu = 3'd2;
              6'd37: alu = 3'd3;
              6'd42: alu = 3'd4;
              default: legal = 1'b0;
            endcase
      6'd35, 6'd43: alu = 3'd0;
      6'd4, 6'd5:   alu = 3'd1;
      6'd2:         alu = 3'd0;
      default:      legal = 1'b0;
    endcase
    bub = flush || !if_valid || st || !legal;
    e_ill = if_valid && !flush && !legal;
    e_A   = mread(IR[25:21]);
    e_MD  = mread(IR[20:16]);
    e_imm = {{16{IR[15]}}, IR[15:0]};
    e_B   = (op == 6'd35 || op == 6'd43) ? e_imm : e_MD;
    e_JT  = {PC[31:28], IR[25:0], 2'b00};
    e_PC  = PC;
    e_valid = !bub;
    e_mtr = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_br = 0; e_bne = 0; e_j = 0; e_alu = 0; e_rd = 0;
    if (!bub) begin
      e_alu = alu;
      case (op)
        6'd0:  begin e_rw = 1; e_rd = IR[15:11]; end
        6'd35: begin e_mr = 1; e_mtr = 1; e_rw = 1; e_rd = IR[20:16]; end
        6'd43: e_mw = 1;
        6'd4:  e_br = 1;
        6'd5:  e_bne = 1;
        default: e_j = 1;
      endcase
    end
    if (st && e_cnt != 2'd3) e_cnt = e_cnt + 2'd1;
    if (MW_RegWrite && MW_RD != 5'd0) mrf[MW_RD] = MW_MemtoReg ? MDR : MW_ALUout;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk1("stall", stall, exp_stall());
        chk("ctrl", 32'({MemtoReg, RegWrite, MemRead, MemWrite, branch, bne, jump, ALUctr, RD, dx_valid, illegal}),
                    32'({e_mtr, e_rw, e_mr, e_mw, e_br, e_bne, e_j, e_alu, e_rd, e_valid, e_ill}));
        chk("stall_cnt", 32'(stall_cnt), 32'(e_cnt));
        if (e_valid) begin
          chk("A", A, e_A);
          chk("B", B, e_B);
          chk("MD", MD, e_MD);
          chk("imm", imm, e_imm);
          chk("JT", JT, e_JT);
          chk("DX_PC", DX_PC, e_PC);
          chk("NPC", NPC, e_PC);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ir, input logic [31:0] pc);
    IR = ir; PC = pc; if_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    cmp_en = 1'b1;
    chk1("rst_dx_valid", dx_valid, 1'b0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_A", A, 32'd0);
    rst = 1'b1;

    // WB write to r3 bypassed into the same-cycle read
    put(rtype(6'd32, 5'd4, 5'd3, 5'd0), 32'h100);
    MW_RegWrite = 1; MW_RD = 5'd3; MW_MemtoReg = 0; MW_ALUout = 32'h1234; MDR = 32'hffff;
    tick();
    chk("t1_A", A, 32'h00001234);
    chk1("t1_valid", dx_valid, 1'b1);
    chk("t1_RD", 32'(RD), 32'd4);
    put(rtype(6'd34, 5'd2, 5'd1, 5'd3), 32'h104);
    MW_RD = 5'd1; MW_MemtoReg = 1; MDR = 32'h11;
    tick();
    MW_RegWrite = 0;
    chk("sub_A", A, 32'h11);
    chk("sub_B", B, 32'h1234);
    chk("sub_ALUctr", 32'(ALUctr), 32'd1);

    // load-use stall
    put(itype(6'd35, 5'd1, 5'd5, 16'd8), 32'h108);
    tick();
    chk1("lw_MemRead", MemRead, 1'b1);
    chk("lw_B", B, 32'd8);
    put(rtype(6'd32, 5'd6, 5'd5, 5'd1), 32'h10c);
    DX_MemRead = 1; DX_RD_in = 5'd5;
    #1 chk1("t2_stall", stall, 1'b1);
    tick();
    chk1("t2_dx_valid", dx_valid, 1'b0);
    chk("t2_cnt", 32'(stall_cnt), 32'd1);
    DX_MemRead = 0;
    tick();
    chk1("t2_add_valid", dx_valid, 1'b1);

    // flush wins over a hazard
    put(itype(6'd43, 5'd2, 5'd5, 16'd4), 32'h110);
    DX_MemRead = 1; DX_RD_in = 5'd5; flush = 1;
    #1 chk1("t3_stall", stall, 1'b0);
    tick();
    chk1("t3_dx_valid", dx_valid, 1'b0);
    chk1("t3_MemWrite", MemWrite, 1'b0);
    chk("t3_cnt", 32'(stall_cnt), 32'd1);
    flush = 0; DX_MemRead = 0;

    put(32'h14220003, 32'h114);
    tick();
    chk1("t4_bne", bne, 1'b1);
    chk1("t4_branch", branch, 1'b0);
    chk("t4_ALUctr", 32'(ALUctr), 32'd1);
    chk("t4_imm", imm, 32'd3);
    chk1("t4_RegWrite", RegWrite, 1'b0);
    put(itype(6'd4, 5'd1, 5'd2, 16'hfffe), 32'h118);
    tick();
    chk("beq_imm", imm, 32'hfffffffe);
    chk1("beq_branch", branch, 1'b1);

    put(32'h08000040, 32'hA0000004);
    tick();
    chk1("t5_jump", jump, 1'b1);
    chk("t5_JT", JT, 32'hA0000100);

    // illegal opcode, then writes to r0 are discarded
    put(32'hFC000000, 32'h11c);
    tick();
    chk1("t6_illegal", illegal, 1'b1);
    chk1("t6_dx_valid", dx_valid, 1'b0);
    put(rtype(6'd32, 5'd7, 5'd0, 5'd0), 32'h120);
    MW_RegWrite = 1; MW_RD = 5'd0; MW_MemtoReg = 0; MW_ALUout = 32'hdead;
    tick();
    MW_RegWrite = 0;
    chk1("t6_illegal_off", illegal, 1'b0);
    chk("t6_r0_bypass", A, 32'd0);
    put(rtype(6'd37, 5'd8, 5'd0, 5'd3), 32'h124);
    tick();
    chk("r0_A", A, 32'd0);
    chk("or_ALUctr", 32'(ALUctr), 32'd3);
    put(rtype(6'd36, 5'd9, 5'd3, 5'd1), 32'h128); tick();
    put(rtype(6'd42, 5'd9, 5'd3, 5'd1), 32'h12c); tick();
    chk("slt_ALUctr", 32'(ALUctr), 32'd4);
    put(rtype(6'd8, 5'd0, 5'd3, 5'd0), 32'h130); tick();
    chk1("funct_illegal", illegal, 1'b1);
    put(itype(6'd35, 5'd1, 5'd5, 16'd0), 32'h134); if_valid = 0; tick();
    chk1("novalid_dx", dx_valid, 1'b0);
    chk1("novalid_ill", illegal, 1'b0);

    // r0 as load destination and rt of a load never stall
    put(itype(6'd35, 5'd0, 5'd9, 16'd0), 32'h138); tick();
    DX_MemRead = 1; DX_RD_in = 5'd0;
    put(rtype(6'd32, 5'd1, 5'd0, 5'd0), 32'h13c);
    #1 chk1("rd0_nostall", stall, 1'b0);
    DX_RD_in = 5'd9;
    put(itype(6'd35, 5'd2, 5'd9, 16'd0), 32'h13c);
    #1 chk1("lw_rt_nostall", stall, 1'b0);
    tick();
    DX_MemRead = 0;

    // saturation of the 2-bit counter
    for (int k = 0; k < 3; k++) begin
      DX_MemRead = 0;
      put(itype(6'd35, 5'd0, 5'd9, 16'd0), 32'h140); tick();
      DX_MemRead = 1; DX_RD_in = 5'd9;
      put(rtype(6'd36, 5'd10, 5'd9, 5'd9), 32'h144); tick();
    end
    chk("sat_cnt", 32'(stall_cnt), 32'd3);

    // reset in the middle of a stall
    DX_MemRead = 0;
    put(itype(6'd35, 5'd0, 5'd9, 16'd0), 32'h148); tick();
    DX_MemRead = 1; DX_RD_in = 5'd9;
    put(rtype(6'd32, 5'd10, 5'd9, 5'd0), 32'h14c);
    #1 chk1("mid_stall", stall, 1'b1);
    rst = 1'b0;
    #1 chk1("mid_rst_stall", stall, 1'b0);
    chk1("mid_rst_valid", dx_valid, 1'b0);
    chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b1; DX_MemRead = 0;
    put(rtype(6'd32, 5'd4, 5'd3, 5'd0), 32'h150);
    tick();
    chk("rf_cleared", A, 32'd0);
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
